// File: rtl/add_sub_pkg.sv
// Shared op encoding for the pipelined adder-subtractor.
package add_sub_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD  = 2'b00;
  localparam op_t OP_SUB  = 2'b01;
  localparam op_t OP_MSUB = 2'b10;
  localparam op_t OP_SADD = 2'b11;

  // SUB and MSUB both run as a + ~b + 1 through the carry chain.
  function automatic logic op_subtracts(input op_t op);
    return (op == OP_SUB) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/add_sub_slice.sv
// One CHUNK-wide slice of the carry chain.
module add_sub_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub/magnitude-sub/saturating-add with valid/ready on both sides.
// WIDTH must be a multiple of STAGES; one CHUNK slice per stage plus a flag/output stage.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             neg,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  // Handshake: a stage loads when it is empty or its successor loads in the same
  // cycle; index STAGES is the output register, whose successor is the consumer.
  logic [STAGES:0]   vld_q;
  logic [STAGES:0]   rdy;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] c_q;
  op_t               op_q  [STAGES];

  logic [CHUNK-1:0]  sl_sum [STAGES];
  logic [STAGES-1:0] sl_co;

  logic [WIDTH-1:0]  b_eff;
  logic              cin0;

  assign cin0  = op_subtracts(op);
  assign b_eff = cin0 ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_first
      add_sub_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a[CHUNK-1:0]),
        .b    (b_eff[CHUNK-1:0]),
        .cin  (cin0),
        .sum  (sl_sum[0]),
        .cout (sl_co[0])
      );
    end else begin : g_next
      add_sub_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_q[k-1][k*CHUNK +: CHUNK]),
        .b    (b_q[k-1][k*CHUNK +: CHUNK]),
        .cin  (c_q[k-1]),
        .sum  (sl_sum[k]),
        .cout (sl_co[k])
      );
    end
  end

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = !vld_q[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !vld_q[k] || rdy[k+1];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[STAGES];

  logic [WIDTH-1:0] s_nx;
  logic             co_nx;
  logic             neg_nx;
  logic             ovf_nx;

  // b_q holds the possibly-inverted b, so one overflow rule serves ADD and SUB.
  always_comb begin
    s_nx   = sum_q[L];
    co_nx  = c_q[L];
    neg_nx = 1'b0;
    ovf_nx = 1'b0;
    case (op_q[L])
      OP_ADD, OP_SUB: begin
        ovf_nx = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) &&
                 (sum_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
      end
      OP_MSUB: begin
        neg_nx = !c_q[L];
        if (!c_q[L]) s_nx = -sum_q[L];
      end
      OP_SADD: begin
        if (c_q[L]) s_nx = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        op_q[k]  <= OP_ADD;
      end
      s   <= '0;
      co  <= 1'b0;
      neg <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (rdy[0]) begin
        vld_q[0] <= in_valid;
        a_q[0]   <= a;
        b_q[0]   <= b_eff;
        op_q[0]  <= op;
        c_q[0]   <= sl_co[0];
        sum_q[0] <= WIDTH'(sl_sum[0]);
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_q[k-1];
          a_q[k]   <= a_q[k-1];
          b_q[k]   <= b_q[k-1];
          op_q[k]  <= op_q[k-1];
          c_q[k]   <= sl_co[k];
          sum_q[k] <= sum_q[k-1];
          sum_q[k][k*CHUNK +: CHUNK] <= sl_sum[k];
        end
      end
      if (rdy[STAGES]) begin
        vld_q[STAGES] <= vld_q[L];
        if (vld_q[L]) begin
          s   <= s_nx;
          co  <= co_nx;
          neg <= neg_nx;
          ovf <= ovf_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed and streaming bench for add_sub_pipe at 16/2, 16/1, 16/16 and 32/4.
module tb_add_sub_pipe;
  import add_sub_pkg::*;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  op_t         op  = OP_ADD;

  logic r0, r1, r2, r3, all_rdy, iv;
  logic ov0, ov1, ov2, ov3;
  logic [15:0] s0, s1, s2;
  logic [31:0] s3;
  logic co0, co1, co2, co3, ng0, ng1, ng2, ng3, of0, of1, of2, of3;

  // All four pipes see a beat only when all can take it, so they stay in step.
  assign all_rdy = r0 & r1 & r2 & r3;
  assign iv      = in_valid && all_rdy;

  add_sub_pipe #(.WIDTH(16), .STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(r0), .a(a32[15:0]), .b(b32[15:0]),
    .op(op), .out_valid(ov0), .out_ready(out_ready), .s(s0), .co(co0), .neg(ng0), .ovf(of0));
  add_sub_pipe #(.WIDTH(16), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(r1), .a(a32[15:0]), .b(b32[15:0]),
    .op(op), .out_valid(ov1), .out_ready(out_ready), .s(s1), .co(co1), .neg(ng1), .ovf(of1));
  add_sub_pipe #(.WIDTH(16), .STAGES(16)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(r2), .a(a32[15:0]), .b(b32[15:0]),
    .op(op), .out_valid(ov2), .out_ready(out_ready), .s(s2), .co(co2), .neg(ng2), .ovf(of2));
  add_sub_pipe #(.WIDTH(32), .STAGES(4)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(r3), .a(a32), .b(b32),
    .op(op), .out_valid(ov3), .out_ready(out_ready), .s(s3), .co(co3), .neg(ng3), .ovf(of3));

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [34:0] exp0_q[$];
  logic [34:0] exp1_q[$];
  logic [34:0] exp2_q[$];
  logic [34:0] exp3_q[$];
  logic [34:0] cur16, cur32;
  logic acc       = 1'b0;
  logic last_ov0  = 1'b0;
  logic saw_stall = 1'b0;
  logic rand_or   = 1'b0;
  int   hold_cnt  = 0;

  function automatic logic [34:0] pk(input logic f_ovf, input logic f_neg,
                                     input logic f_co, input logic [31:0] f_s);
    return {f_ovf, f_neg, f_co, f_s};
  endfunction

  function automatic logic [34:0] model(input int w, input op_t o,
                                        input logic [31:0] a_i, input logic [31:0] b_i);
    longint mask, half, ua, ub, sa, sb, r, rs;
    logic m_co, m_neg, m_ovf;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ua    = longint'(a_i) & mask;
    ub    = longint'(b_i) & mask;
    sa    = (ua >= half) ? ua - (mask + 1) : ua;
    sb    = (ub >= half) ? ub - (mask + 1) : ub;
    m_co  = 1'b0;
    m_neg = 1'b0;
    m_ovf = 1'b0;
    r     = 0;
    rs    = 0;
    case (o)
      OP_ADD: begin
        r = ua + ub; m_co = (r > mask); rs = sa + sb; m_ovf = (rs >= half) || (rs < -half);
      end
      OP_SUB: begin
        r = ua - ub; m_co = (ua >= ub); rs = sa - sb; m_ovf = (rs >= half) || (rs < -half);
      end
      OP_MSUB: begin
        m_neg = (ua < ub); r = m_neg ? ub - ua : ua - ub; m_co = !m_neg;
      end
      default: begin
        r = ua + ub; m_co = (r > mask); if (m_co) r = mask;
      end
    endcase
    return {m_ovf, m_neg, m_co, 32'(r & mask)};
  endfunction

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_avail(input string tag, input int n);
    checks++;
    assert (n > 0) else begin
      errors++;
      $error("FAIL %s observed=extra_beat expected=no_beat", tag);
    end
  endtask

  // One clock: sample handshakes at the falling edge, advance, then update out_ready.
  task automatic cycle();
    @(negedge clk);
    last_ov0 = ov0;
    if (in_valid && !r0) saw_stall = 1'b1;
    acc = iv;
    if (iv) begin
      exp0_q.push_back(cur16);
      exp1_q.push_back(cur16);
      exp2_q.push_back(cur16);
      exp3_q.push_back(cur32);
    end
    if (out_ready) begin
      if (ov0) begin
        chk_avail("u0_extra", exp0_q.size());
        if (exp0_q.size() > 0) chk("u0_result", pk(of0, ng0, co0, {16'h0, s0}), exp0_q.pop_front());
      end
      if (ov1) begin
        chk_avail("u1_extra", exp1_q.size());
        if (exp1_q.size() > 0) chk("u1_result", pk(of1, ng1, co1, {16'h0, s1}), exp1_q.pop_front());
      end
      if (ov2) begin
        chk_avail("u2_extra", exp2_q.size());
        if (exp2_q.size() > 0) chk("u2_result", pk(of2, ng2, co2, {16'h0, s2}), exp2_q.pop_front());
      end
      if (ov3) begin
        chk_avail("u3_extra", exp3_q.size());
        if (exp3_q.size() > 0) chk("u3_result", pk(of3, ng3, co3, s3), exp3_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (hold_cnt > 0) hold_cnt--;
    out_ready = (hold_cnt == 0) && (!rand_or || ($urandom_range(0, 1) == 1));
  endtask

  // driver
  task automatic send(input op_t o, input logic [31:0] a_i, input logic [31:0] b_i,
                      input logic [34:0] e16);
    op       = o;
    a32      = a_i;
    b32      = b_i;
    cur16    = e16;
    cur32    = model(32, o, a_i, b_i);
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) cycle();
    chk("accept", {34'b0, acc}, 35'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while ((exp0_q.size() + exp1_q.size() + exp2_q.size() + exp3_q.size()) > 0 && n < 400) begin
      cycle();
      n++;
    end
    chk("drain", 35'(exp0_q.size() + exp1_q.size() + exp2_q.size() + exp3_q.size()), 35'd0);
  endtask

  task automatic send_rand();
    op_t         o;
    logic [31:0] ra, rb;
    o  = op_t'($urandom_range(0, 3));
    ra = $urandom();
    rb = $urandom();
    if ($urandom_range(0, 3) == 0) rb = ra;
    send(o, ra, rb, model(16, o, ra, rb));
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_u0_out", pk(of0, ng0, co0, {16'h0, s0}), 35'd0);
    chk("rst_u3_out", pk(of3, ng3, co3, s3), 35'd0);
    chk("rst_valid", {31'b0, ov0, ov1, ov2, ov3}, 35'd0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", {31'b0, r0, r1, r2, r3}, 35'hF);

    // first beat: latency STAGES+1 on the 16/2 pipe
    send(OP_ADD, 32'h0000_FFFF, 32'h0000_0001, pk(0, 0, 1, 32'h0000));
    in_valid = 1'b0;
    cycle();
    chk("latency_c1", {34'b0, last_ov0}, 35'd0);
    cycle();
    chk("latency_c2", {34'b0, last_ov0}, 35'd0);
    cycle();
    chk("latency_c3", {34'b0, last_ov0}, 35'd1);
    drain();

    // directed vectors, back to back with mixed ops
    send(OP_ADD,  32'h0000_7FFF, 32'h0000_0001, pk(1, 0, 0, 32'h8000));
    send(OP_SUB,  32'h0000_0005, 32'h0000_0003, pk(0, 0, 1, 32'h0002));
    send(OP_SUB,  32'h0000_8000, 32'h0000_0001, pk(1, 0, 1, 32'h7FFF));
    send(OP_SUB,  32'h0000_0000, 32'h0000_0001, pk(0, 0, 0, 32'hFFFF));
    send(OP_MSUB, 32'h0000_0003, 32'h0000_0005, pk(0, 1, 0, 32'h0002));
    send(OP_MSUB, 32'h0000_1234, 32'h0000_1234, pk(0, 0, 1, 32'h0000));
    send(OP_MSUB, 32'h0000_0000, 32'h0000_FFFF, pk(0, 1, 0, 32'hFFFF));
    send(OP_SADD, 32'h0000_F000, 32'h0000_2000, pk(0, 0, 1, 32'hFFFF));
    send(OP_SADD, 32'h0000_0001, 32'h0000_0002, pk(0, 0, 0, 32'h0003));
    send(OP_ADD,  32'h0000_8000, 32'h0000_8000, pk(1, 0, 1, 32'h0000));
    drain();

    // back-pressure: consumer stalls 5 cycles mid-stream
    saw_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        hold_cnt  = 5;
        out_ready = 1'b0;
      end
      send_rand();
    end
    drain();
    chk("in_ready_fell", {34'b0, saw_stall}, 35'd1);

    // random consumer readiness
    rand_or = 1'b1;
    for (int i = 0; i < 20; i++) send_rand();
    rand_or   = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset with beats in flight; output regs hold a known nonzero result first
    send(OP_SADD, 32'h0000_F000, 32'h0000_2000, pk(0, 0, 1, 32'hFFFF));
    drain();
    send(OP_ADD, 32'h0000_1111, 32'h0000_2222, pk(0, 0, 0, 32'h3333));
    send(OP_SUB, 32'h0000_0009, 32'h0000_0004, pk(0, 0, 1, 32'h0005));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_u0_out", pk(of0, ng0, co0, {16'h0, s0}), 35'd0);
    chk("mid_rst_u3_out", pk(of3, ng3, co3, s3), 35'd0);
    chk("mid_rst_valid", {31'b0, ov0, ov1, ov2, ov3}, 35'd0);
    exp0_q.delete();
    exp1_q.delete();
    exp2_q.delete();
    exp3_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst2", {31'b0, r0, r1, r2, r3}, 35'hF);
    send(OP_MSUB, 32'h0000_0010, 32'h0000_0030, pk(0, 1, 0, 32'h0020));
    drain();
    repeat (20) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
